// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: serial transmitter sending each data bit as three identical beats with start/last frame markers
module rep3_serial_tx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_start,
  output logic             tx_last,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [WIDTH-1:0] sh, sh_n;
  logic [BW-1:0] idx, idx_n;
  logic [1:0] rep, rep_n;
  logic adv, load, wrap;
  assign wrap = rep == 2'd2;
  always_comb begin
    rep_n = wrap ? 2'd0 : rep + 2'd1;
    idx_n = wrap ? idx + 1'b1 : idx;
    sh_n = wrap ? (MSB_FIRST ? sh << 1 : sh >> 1) : sh;
  end
  assign in_ready = !rst && (state == IDLE || (state == SEND && tx_last && tx_ready));
  assign adv = tx_valid && tx_ready;
  assign load = in_valid && in_ready;
  assign busy = tx_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      rep <= '0;
      tx_valid <= 1'b0;
      tx_bit <= 1'b0;
      tx_start <= 1'b0;
      tx_last <= 1'b0;
    end else if (load) begin
      state <= SEND;
      sh <= in_data;
      idx <= '0;
      rep <= '0;
      tx_valid <= 1'b1;
      tx_bit <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
      tx_start <= 1'b1;
      tx_last <= 1'b0;
    end else if (adv && tx_last) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      rep <= '0;
      tx_valid <= 1'b0;
      tx_bit <= 1'b0;
      tx_start <= 1'b0;
      tx_last <= 1'b0;
    end else if (adv) begin
      sh <= sh_n;
      idx <= idx_n;
      rep <= rep_n;
      tx_bit <= MSB_FIRST ? sh_n[WIDTH-1] : sh_n[0];
      tx_start <= 1'b0;
      tx_last <= idx_n == LAST_IDX && rep_n == 2'd2;
    end
  end
endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb_rep3_serial_tx: directed and random stimulus against a frame-position reference model, msb- and lsb-first
module tb_rep3_serial_tx;
  localparam int W = 8;
  localparam int FL = 3 * W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic tx_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, tx_valid, tx_bit, tx_start, tx_last, busy;
  logic l_in_ready, l_tx_valid, l_tx_bit, l_tx_start, l_tx_last, l_busy;
  int checks = 0;
  int errors = 0;
  bit m_active = 1'b0;
  bit m_clr = 1'b1;
  logic [W-1:0] m_word = '0;
  int m_pos = 0;
  int accepts = 0;
  always #5 clk = ~clk;
  rep3_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_start(tx_start),
    .tx_last(tx_last), .busy(busy)
  );
  rep3_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .tx_ready(tx_ready), .tx_valid(l_tx_valid), .tx_bit(l_tx_bit), .tx_start(l_tx_start),
    .tx_last(l_tx_last), .busy(l_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic er;
    @(negedge clk);
    er = !rst && (!m_active || (m_pos == FL - 1 && tx_ready));
    check("in_ready", in_ready, er);
    check("l_in_ready", l_in_ready, er);
    check("tx_valid", tx_valid, m_active);
    check("l_tx_valid", l_tx_valid, m_active);
    check("busy", busy, m_active);
    check("l_busy", l_busy, m_active);
    if (m_active) begin
      check("tx_bit", tx_bit, m_word[W-1-m_pos/3]);
      check("l_tx_bit", l_tx_bit, m_word[m_pos/3]);
      check("tx_start", tx_start, m_pos == 0);
      check("l_tx_start", l_tx_start, m_pos == 0);
      check("tx_last", tx_last, m_pos == FL - 1);
      check("l_tx_last", l_tx_last, m_pos == FL - 1);
    end else if (m_clr) begin
      check("rst_tx_bit", tx_bit, 0);
      check("rst_l_tx_bit", l_tx_bit, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_last", tx_last, 0);
    end
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_pos = 0;
      m_clr = 1'b1;
    end else if (er && in_valid) begin
      m_active = 1'b1;
      m_word = in_data;
      m_pos = 0;
      m_clr = 1'b0;
      accepts++;
    end else if (m_active && tx_ready) begin
      if (m_pos == FL - 1) m_active = 1'b0;
      else m_pos++;
    end
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_accept(input string tag, input int target);
    for (int i = 0; i < 4 * FL && accepts < target; i++) step();
    check(tag, accepts, target);
  endtask
  initial begin
    in_valid = 1'b1;
    in_data = 8'h77;
    run(2);
    rst = 1'b0;
    in_valid = 1'b0;
    run(2);
    send(8'hA5);
    run(FL + 2);
    send(8'hA5);
    run(4);
    tx_ready = 1'b0;
    run(5);
    tx_ready = 1'b1;
    run(FL);
    in_valid = 1'b1;
    in_data = 8'hA5;
    step();
    in_data = 8'h3C;
    wait_accept("b2b_accept", accepts + 1);
    in_valid = 1'b0;
    run(FL + 2);
    send(8'h01);
    run(FL + 2);
    send(8'hA5);
    run(9);
    in_valid = 1'b1;
    in_data = 8'hFF;
    wait_accept("ignored_accept", accepts + 1);
    in_valid = 1'b0;
    run(FL + 2);
    send(8'hA5);
    run(9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2);
    send(8'h0F);
    run(FL + 2);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 100) == 0;
      in_valid = ($urandom % 2) == 0;
      in_data = W'($urandom);
      tx_ready = ($urandom % 4) != 0;
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b1;
    run(FL + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
